// File: rtl/paritychk.sv
// Serial even-parity frame checker: deserialises DATA_W bits MSB-first, then checks the parity bit.
// Optional saturating error counter is built only when PARITYCHK_ERRCNT_EN is defined.
module paritychk #(
    parameter int DATA_W    = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_p,
    input  logic                 ip,
    input  logic                 ip_vld,
    input  logic                 sof,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_vld,
    output logic                 par_err,
    output logic                 frame_abort,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PAR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_sreg;
    logic [CW-1:0]     r_cnt;
    logic              r_par;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_vld;
    logic              r_par_err;
    logic              r_abort;

    logic w_start;
    logic w_shift;
    logic w_done;
    logic w_abort;
    logic w_last;

    assign w_start = sof & ip_vld;
    assign w_last  = (r_cnt == CW'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_DATA;
            end
            S_DATA: begin
                if (w_start)
                    w_next = S_DATA;
                else if (ip_vld && w_last)
                    w_next = S_PAR;
            end
            S_PAR: begin
                if (w_start)
                    w_next = S_DATA;
                else if (ip_vld)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // sof always takes priority over a data or parity bit
    always_comb begin
        w_shift = 1'b0;
        w_done  = 1'b0;
        w_abort = 1'b0;
        unique case (r_state)
            S_IDLE: ;
            S_DATA: begin
                w_shift = ip_vld & ~sof;
                w_abort = w_start;
            end
            S_PAR: begin
                w_done  = ip_vld & ~sof;
                w_abort = w_start;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_par  <= 1'b0;
        end else if (w_start) begin
            r_sreg <= {{(DATA_W-1){1'b0}}, ip};
            r_cnt  <= CW'(1);
            r_par  <= ip;
        end else if (w_shift) begin
            r_sreg <= {r_sreg[DATA_W-2:0], ip};
            r_cnt  <= r_cnt + 1'b1;
            r_par  <= r_par ^ ip;
        end
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            r_data_out <= '0;
            r_data_vld <= 1'b0;
            r_par_err  <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_data_vld <= w_done;
            r_par_err  <= w_done & (ip ^ r_par);
            r_abort    <= w_abort;
            if (w_done) r_data_out <= r_sreg;
        end
    end

`ifdef PARITYCHK_ERRCNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            r_err_cnt <= '0;
        end else if (w_done && (ip ^ r_par) && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

    assign data_out    = r_data_out;
    assign data_vld    = r_data_vld;
    assign par_err     = r_par_err;
    assign frame_abort = r_abort;

endmodule

// File: doc/paritychk.md
# paritychk

Serial even-parity frame checker: the receive-side counterpart of the serial parity generator. It accepts a bit-serial frame of DATA_W data bits followed by one parity bit and deserialises the data into a parallel word. It then checks that the parity bit equals the XOR of the data bits and reports the result with single-cycle strobes. It sits at the receive end of the serial peripheral link, ahead of the parallel consumer.

## Interface
- DATA_W, 32, data bits per frame (2..64)
- ERR_CNT_W, 8, width of saturating parity-error counter
- clk  in  1  system clock, all logic on rising edge
- rst_p  in  1  asynchronous, active-high reset
- ip  in  1  serial data/parity bit
- ip_vld  in  1  ip is valid this cycle; bits are sampled only when high
- sof  in  1  start of frame; qualified by ip_vld, marks the first data bit
- data_out  out  DATA_W  last deserialised word, first received bit at MSB
- data_vld  out  1  one-cycle strobe: frame complete, data_out updated
- par_err  out  1  one-cycle strobe coincident with data_vld when parity mismatched
- frame_abort  out  1  one-cycle strobe: partial frame discarded by a new sof
- err_cnt  out  ERR_CNT_W  count of frames with parity error, saturating

Clock and reset are fixed: one clock; reset is asynchronous and active-high (ports clk and rst_p).

## Operation
- States: IDLE, DATA, PAR.
- IDLE: bits are ignored until sof & ip_vld. That bit is data bit 0. It is loaded into the shift register, and the running XOR is set to ip. The bit counter is set to 1 and the state moves to DATA (or to PAR if DATA_W==1, which is unsupported, so min DATA_W=2).
- DATA: each ip_vld shifts ip in at the LSB (shift left) and XORs ip into the running parity. The counter increments. When the counter reaches DATA_W after a shift, the state moves to PAR.
- PAR: the next ip_vld is the parity bit. The state returns to IDLE, and on the following edge the outputs update:
  - data_out is loaded with the shift register.
  - data_vld pulses for 1 cycle.
  - par_err = ip XOR running parity.
- Even parity: par_err=0 when XOR(data bits, parity bit)=0.
- data_out updates on every completed frame, good or bad. It holds its value otherwise.
- sof & ip_vld while in DATA or PAR:
  - frame_abort pulses for 1 cycle, and no data_vld is issued.
  - That bit starts a new frame as data bit 0, and the state moves to DATA.
  - sof wins over the parity bit.
- sof without ip_vld is ignored in all states.
- ip_vld gaps of any length are allowed in any state. State, counter and parity hold.
- err_cnt increments on each par_err strobe and saturates at 2^ERR_CNT_W−1. It is cleared only by reset.

## Timing
- Reset values: data_out=0, data_vld=0, par_err=0, frame_abort=0, err_cnt=0, state=IDLE, counter=0.
- Reset asserted mid-frame discards the partial frame with no strobe. The first frame after reset requires a fresh sof.
- Latency: data_vld/par_err assert on the edge after the clock that samples the parity bit (1 cycle).
- frame_abort asserts on the edge after the clock that samples the aborting sof.
- Back-to-back frames: sof & ip_vld may arrive the cycle immediately after the parity bit. data_vld for the old frame and acceptance of the new bit occur without loss.
- Minimum frame duration is DATA_W+1 ip_vld cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- PARITYCHK_ERRCNT_EN defined: the err_cnt register and saturating increment are built as described.
- PARITYCHK_ERRCNT_EN undefined: no counter logic is built, and err_cnt is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then sof+32 bits of 0xA5A5A5A5 MSB-first with continuous ip_vld, then parity bit 0 -> data_vld 1 cycle, data_out=0xA5A5A5A5, par_err=0, err_cnt=0.
- Same frame with parity bit 1 -> data_vld and par_err both pulse, data_out=0xA5A5A5A5, err_cnt=1.
- Frame 0x00000001, parity 1, with ip_vld low every other cycle -> data_out=0x00000001, par_err=0. The strobe lands exactly 1 cycle after the parity sample.
- sof+10 bits, then a new sof + full frame 0xFFFFFFFF with parity 0 -> frame_abort 1 cycle after the second sof, one data_vld, data_out=0xFFFFFFFF, par_err=0.
- Assert rst_p after 20 data bits, release, then send bits without sof -> all outputs 0, no strobes. A subsequent sof frame decodes correctly.
- 300 consecutive bad-parity frames with PARITYCHK_ERRCNT_EN defined -> err_cnt=255 (ERR_CNT_W=8). Without the macro -> err_cnt stays 0 while par_err still pulses 300 times.
